// File: rtl/rr_arbiter8_pkg.sv
// Shared arbiter types and helpers: FSM state encoding, default requester
// count, and a one-hot to binary index converter for grant checkers.
package arb_pkg;

  localparam int ARB_N     = 8;
  localparam int ARB_IDX_W = $clog2(ARB_N);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // OR-reduce the indices of set bits; exact for one-hot or zero inputs.
  function automatic logic [ARB_IDX_W-1:0] onehot_to_idx(input logic [ARB_N-1:0] oh);
    logic [ARB_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_N; i++)
      if (oh[i]) idx = idx | ARB_IDX_W'(i);
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the arbiter and its requesters/consumer.
// master: the arbiter (drives grants). slave: requesters and beat consumer.
interface rr_arbiter8_if #(
  parameter int N     = 8,
  parameter int IDX_W = 3
);
  logic [N-1:0]     req;
  logic             ack;
  logic             last;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;

  modport master (input req, ack, last, output gnt, gnt_idx, gnt_valid);
  modport slave  (output req, ack, last, input gnt, gnt_idx, gnt_valid);
endinterface

// File: rtl/rr_arbiter8_pick.sv
// Round-robin winner selection: rotate requests so 'base' sits at bit 0,
// take the lowest set bit, then add 'base' back modulo N.
module rr_pick #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] base,
  output logic             any,
  output logic [IDX_W-1:0] win_idx
);

  logic [N-1:0]   rot;
  logic [IDX_W-1:0] off;
  logic [IDX_W:0]   sum;

  // rotate-right, fixed-priority find-first, then un-rotate
  always_comb begin
    for (int i = 0; i < N; i++) begin
      int j;
      j = i + int'(base);
      if (j >= N) j = j - N;
      rot[i] = req[j];
    end
    off = '0;
    for (int i = N - 1; i >= 0; i--)
      if (rot[i]) off = IDX_W'(i);
    sum = {1'b0, off} + {1'b0, base};
    if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
    win_idx = sum[IDX_W-1:0];
    any     = |req;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter with held multi-beat grants. Grants are registered in
// both one-hot and binary form; every grant is followed by one idle cycle so
// downstream mux selects only move while gnt_valid is low.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int N         = ARB_N,
  parameter int IDX_W     = $clog2(N),
  parameter int MAX_BEATS = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  rr_arbiter8_if.master bus
);

  localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  arb_state_e       state_q, state_d;
  logic [N-1:0]     gnt_q,   gnt_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [IDX_W-1:0] ptr_q,   ptr_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic             any;
  logic [IDX_W-1:0] win_idx;
  logic             rel;

  rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
    .req     (bus.req),
    .base    (ptr_q),
    .any     (any),
    .win_idx (win_idx)
  );

  // Release: final beat, beat limit reached, or owner withdrew its request.
  assign rel = (bus.ack && (bus.last || cnt_q == CNT_W'(MAX_BEATS - 1)))
             || !bus.req[idx_q];

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any) state_d = GRANT;
      GRANT:   if (rel) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // grant, pointer and beat-count next values
  always_comb begin
    gnt_d = gnt_q;
    idx_d = idx_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: begin
        if (any) begin
          gnt_d = N'(1) << win_idx;
          idx_d = win_idx;
          cnt_d = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          gnt_d = '0;
          idx_d = '0;
          ptr_d = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + IDX_W'(1);
        end else if (bus.ack) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        gnt_d = '0;
        idx_d = '0;
      end
    endcase
  end

  // datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_q <= '0;
      idx_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      gnt_q <= gnt_d;
      idx_q <= idx_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = (state_q == GRANT);

  // grant is one-hot matching the index while held, all-zero when idle
  a_gnt_onehot : assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == IDLE) ? (gnt_q == '0 && idx_q == '0)
                      : (gnt_q == (N'(1) << idx_q)));

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: reset, fairness, sparse wrap, beat limit,
// abort, async reset mid-grant, and simultaneous abort with last beat.
module tb_rr_arbiter8;
  import arb_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  rr_arbiter8_if #(.N(8), .IDX_W(3)) bus  ();
  rr_arbiter8_if #(.N(8), .IDX_W(3)) bus4 ();

  rr_arbiter8 #(.N(8), .IDX_W(3), .MAX_BEATS(16)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  rr_arbiter8 #(.N(8), .IDX_W(3), .MAX_BEATS(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .bus(bus4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_gnt(input string tag, input int idx);
    logic [7:0] oh;
    oh = 8'(1) << idx;
    chk({tag, ".gnt"}, 32'(bus.gnt), 32'(oh));
    chk({tag, ".idx"}, 32'(bus.gnt_idx), 32'(idx));
    chk({tag, ".oh2idx"}, 32'(onehot_to_idx(bus.gnt)), 32'(idx));
    chk({tag, ".vld"}, 32'(bus.gnt_valid), 32'd1);
  endtask

  task automatic exp_idle(input string tag);
    chk({tag, ".gnt"}, 32'(bus.gnt), 32'd0);
    chk({tag, ".idx"}, 32'(bus.gnt_idx), 32'd0);
    chk({tag, ".vld"}, 32'(bus.gnt_valid), 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    bus.req = 8'h00; bus.ack = 1'b0; bus.last = 1'b0;
    bus4.req = 8'h00; bus4.ack = 1'b0; bus4.last = 1'b0;

    // 1. reset holds outputs low even with requests and ack present
    bus.req = 8'hFF; bus.ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      exp_idle("rst");
    end
    reset_n = 1'b1;
    tick();
    exp_gnt("rst_rel", 0);

    // 2. fairness with every requester active
    for (int k = 0; k < 8; k++) begin
      exp_gnt($sformatf("fair%0d", k), k);
      bus.ack = 1'b1; bus.last = 1'b1;
      tick();
      exp_idle($sformatf("fair_gap%0d", k));
      bus.ack = 1'b0; bus.last = 1'b0;
      tick();
    end
    exp_gnt("fair_wrap", 0);

    // 3. sparse requests wrap 0 -> 7 -> 0 -> 7
    bus.req = 8'h00; bus.ack = 1'b0; bus.last = 1'b0;
    do_reset();
    bus.req = 8'b1000_0001;
    tick();
    for (int k = 0; k < 4; k++) begin
      exp_gnt($sformatf("sparse%0d", k), (k % 2 == 0) ? 0 : 7);
      bus.ack = 1'b1; bus.last = 1'b1;
      tick();
      exp_idle($sformatf("sparse_gap%0d", k));
      bus.ack = 1'b0; bus.last = 1'b0;
      tick();
    end

    // 4. beat limit on the MAX_BEATS=4 instance
    bus.req = 8'h00;
    do_reset();
    bus4.req = 8'h08; bus4.ack = 1'b1; bus4.last = 1'b0;
    tick();
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("beat%0d.gnt", b), 32'(bus4.gnt), 32'h08);
      chk($sformatf("beat%0d.idx", b), 32'(bus4.gnt_idx), 32'd3);
      if (b < 3) tick();
    end
    tick();
    chk("beat_rel.gnt", 32'(bus4.gnt), 32'h00);
    chk("beat_rel.vld", 32'(bus4.gnt_valid), 32'd0);
    tick();
    chk("beat_regnt.gnt", 32'(bus4.gnt), 32'h08);
    chk("beat_regnt.idx", 32'(bus4.gnt_idx), 32'd3);
    bus4.req = 8'h00; bus4.ack = 1'b0;
    tick();
    chk("beat_abort.vld", 32'(bus4.gnt_valid), 32'd0);

    // 5. abort, last without ack, no preemption
    do_reset();
    bus.req = 8'h20;
    tick();
    exp_gnt("abort_gnt", 5);
    bus.last = 1'b1;
    tick();
    exp_gnt("last_noack", 5);
    bus.last = 1'b0; bus.req = 8'h21;
    tick();
    exp_gnt("no_preempt", 5);
    bus.req = 8'h01;
    tick();
    exp_idle("abort_rel");
    bus.req = 8'h21;
    tick();
    exp_gnt("abort_next", 0);

    // 6. asynchronous reset mid-grant
    bus.req = 8'h00;
    do_reset();
    bus.req = 8'h40;
    tick();
    exp_gnt("mid_gnt", 6);
    bus.ack = 1'b1;
    tick();
    tick();
    exp_gnt("mid_beats", 6);
    bus.ack = 1'b0;
    #2 reset_n = 1'b0;
    #1 exp_idle("mid_async");
    #2 reset_n = 1'b1;
    bus.req = 8'h44;
    tick();
    exp_gnt("mid_after", 2);

    // 7. abort coinciding with last beat: single release, ptr = 3
    bus.req = 8'h40; bus.ack = 1'b1; bus.last = 1'b1;
    tick();
    exp_idle("both_rel");
    bus.ack = 1'b0; bus.last = 1'b0; bus.req = 8'h44;
    tick();
    exp_gnt("both_next", 6);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
